// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic datapath constants and FSM state type
package arith_pkg;

  localparam int WIDTH  = 64;
  localparam int CHUNK  = 16;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Two's-complement overflow of a - b given the three sign bits.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                        input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/seq_subtractor_64_if.sv
// rtl/seq_subtractor_64_if.sv - start/ready/done handshake bundle for the subtractor
interface seq_subtractor_64_if #(
  parameter int WIDTH = arith_pkg::WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;

  modport master (
    output start, a, b,
    input  ready, done, diff, borrow, overflow
  );

  modport slave (
    input  start, a, b,
    output ready, done, diff, borrow, overflow
  );

endinterface

// File: rtl/chunk_subtractor.sv
// rtl/chunk_subtractor.sv - combinational CHUNK-bit a - b - bin slice
module chunk_subtractor #(
  parameter int CHUNK = arith_pkg::CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] diff,
  output logic             bout
);

  logic [CHUNK:0] result;

  // The extra top bit goes to 1 exactly when the slice result is negative.
  assign result = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
  assign diff   = result[CHUNK-1:0];
  assign bout   = result[CHUNK];

endmodule

// File: rtl/seq_subtractor_64.sv
// rtl/seq_subtractor_64.sv - multi-cycle chunked A - B with ripple borrow across cycles
module seq_subtractor_64
  import arith_pkg::*;
#(
  parameter int WIDTH = arith_pkg::WIDTH,
  parameter int CHUNK = arith_pkg::CHUNK
) (
  input  logic                clk,
  input  logic                rst,
  seq_subtractor_64_if.slave  bus
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KWL = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KWL-1:0] K_LAST = KWL'(NCH - 1);

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t           state;
  logic [KWL-1:0]   k;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic             bin;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] d_chunk;
  logic             bout;
  logic [WIDTH-1:0] acc_next;

  assign a_chunk = a_q[int'(k) * CHUNK +: CHUNK];
  assign b_chunk = b_q[int'(k) * CHUNK +: CHUNK];

  chunk_subtractor #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_chunk),
    .b    (b_chunk),
    .bin  (bin),
    .diff (d_chunk),
    .bout (bout)
  );

  // The full result including the chunk being produced this cycle.
  always_comb begin
    acc_next = acc;
    acc_next[int'(k) * CHUNK +: CHUNK] = d_chunk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      k            <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc          <= '0;
      bin          <= 1'b0;
      bus.diff     <= '0;
      bus.borrow   <= 1'b0;
      bus.overflow <= 1'b0;
      bus.done     <= 1'b0;
      bus.ready    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_q       <= bus.a;
            b_q       <= bus.b;
            k         <= '0;
            bin       <= 1'b0;
            acc       <= '0;
            bus.ready <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_next;
          bin <= bout;
          if (k == K_LAST) begin
            bus.diff     <= acc_next;
            bus.borrow   <= bout;
            bus.overflow <= sub_overflow(a_q[WIDTH-1], b_q[WIDTH-1],
                                         acc_next[WIDTH-1]);
            bus.done     <= 1'b1;
            state        <= FINISH;
          end else begin
            k <= k + 1'b1;
          end
        end
        FINISH: begin
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_subtractor_64.sv
// tb/tb_seq_subtractor_64.sv - randomized self-checking bench against an arithmetic reference model
module tb_seq_subtractor_64;

  logic clk;
  logic rst;

  seq_subtractor_64_if bus ();

  seq_subtractor_64 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] prev_diff = '0;
  logic        prev_borrow = 1'b0;
  logic        prev_ovf = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [63:0] av, input logic [63:0] bv,
                       output logic [63:0] d, output logic bo, output logic ov);
    logic [64:0] wide;
    logic signed [64:0] sd;
    wide = {1'b0, av} - {1'b0, bv};
    d    = wide[63:0];
    bo   = (av < bv);
    sd   = $signed({av[63], av}) - $signed({bv[63], bv});
    ov   = (sd > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (sd < -65'sh0_8000_0000_0000_0000);
  endtask

  // One full operation; operand inputs are scrambled while busy.
  task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv);
    logic [63:0] ed;
    logic eb, eo;
    int cyc;
    model(av, bv, ed, eb, eo);
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 20) begin
      if (bus.diff !== prev_diff || bus.ready !== 1'b0) begin
        check({tag, "_busy_hold"}, {bus.ready, bus.diff[62:0]}, {1'b0, prev_diff[62:0]});
      end
      bus.a = {$urandom, $urandom};
      bus.b = {$urandom, $urandom};
      step();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd5);
    check({tag, "_diff"}, bus.diff, ed);
    check({tag, "_borrow"}, 64'(bus.borrow), 64'(eb));
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(eo));
    prev_diff = ed;
    prev_borrow = eb;
    prev_ovf = eo;
    step();
    check({tag, "_ready_back"}, 64'(bus.ready), 64'd1);
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [63:0] ra, rb, sum, ed;
    logic eb, eo;
    int dones;
    int first_done, last_done, spacing_bad;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_diff", bus.diff, 64'd0);
    check("rst_borrow", 64'(bus.borrow), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);

    run_op("basic", 64'h5, 64'h3);
    run_op("all_borrow", 64'h0, 64'h1);
    run_op("chunk_borrow", 64'h0000_0001_0000_0000, 64'h1);
    run_op("ovf_pos", 64'h8000_0000_0000_0000, 64'h1);
    run_op("ovf_neg", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);

    // START held continuously: three DONE pulses within 20 cycles, 6 apart
    bus.a = 64'hDEAD_BEEF_0000_0001;
    bus.b = 64'h0000_0000_FFFF_FFFF;
    bus.start = 1'b1;
    dones = 0;
    first_done = -1;
    last_done = -1;
    spacing_bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.done) begin
        if (last_done >= 0 && c - last_done != 6) spacing_bad++;
        if (first_done < 0) first_done = c;
        last_done = c;
        dones++;
      end
    end
    bus.start = 1'b0;
    check("held_dones", 64'(dones), 64'd3);
    check("held_spacing", 64'(spacing_bad), 64'd0);
    check("held_first", 64'(first_done), 64'd4);
    for (int c = 0; c < 20 && !bus.ready; c++) step();
    step();
    model(64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, ed, eb, eo);
    check("held_diff", bus.diff, ed);
    prev_diff = ed;

    // START during FINISH must be ignored
    bus.a = 64'd100;
    bus.b = 64'd1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 0; c < 20 && !bus.done; c++) step();
    check("fin_done_seen", 64'(bus.done), 64'd1);
    prev_diff = 64'd99;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("fin_ready", 64'(bus.ready), 64'd1);
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.done) dones++;
    end
    check("fin_ignored", 64'(dones), 64'd0);

    // reset in the 2nd BUSY cycle abandons the operation
    bus.a = 64'd77;
    bus.b = 64'd3;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ready", 64'(bus.ready), 64'd1);
    check("mid_rst_diff", bus.diff, 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.done) dones++;
    end
    check("mid_rst_no_done", 64'(dones), 64'd0);
    prev_diff = '0;
    run_op("after_rst", 64'd10, 64'd10);

    // reset wins over a simultaneous START
    rst = 1'b1;
    bus.start = 1'b1;
    step();
    rst = 1'b0;
    bus.start = 1'b0;
    step();
    check("rst_wins", 64'(bus.ready), 64'd1);
    prev_diff = '0;

    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: ra = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, ra[47:0]};
        2: rb = ~ra;
        default: ;
      endcase
      if (i % 4 == 0) begin
        sum = ra + rb;
        run_op("adder_inv", sum, rb);
        check("adder_inv_a", bus.diff, ra);
      end else begin
        run_op("rand", ra, rb);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_subtractor_64.md
# seq_subtractor_64

Multi-cycle 64-bit subtractor, the inverse-operation companion to the 64-bit adder. It computes DIFF = A − B over several clock cycles, CHUNK bits per cycle, LSB first, with a ripple borrow chain. It sits beside the adder in the arithmetic datapath and exposes a START/READY/DONE handshake, so a controller can recover an operand from a sum (A = SUM − B) and cross-check adder results.

## Interface
- WIDTH, 64, operand and result width; must be a multiple of CHUNK
- CHUNK, 16, bits processed per cycle; NCHUNK = WIDTH/CHUNK (4 by default)

- CLK  in  1  clock; everything is on the rising edge
- RST  in  1  reset; synchronous and active-high
- START  in  1  request; sampled only while READY=1
- A  in  WIDTH  minuend; captured on the accepting edge
- B  in  WIDTH  subtrahend; captured on the accepting edge
- READY  out  1  high only in IDLE; may accept START
- DONE  out  1  one-cycle pulse; DIFF/BORROW/OVERFLOW are newly valid
- DIFF  out  WIDTH  A − B mod 2^WIDTH
- BORROW  out  1  1 iff A < B (unsigned)
- OVERFLOW  out  1  two's-complement overflow: A[MSB]≠B[MSB] and DIFF[MSB]≠A[MSB]

## Operation
- States:
  - IDLE: READY=1.
  - BUSY: chunk index k runs 0..NCHUNK−1.
  - FINISH: DONE=1 for one cycle.
- Transitions:
  - IDLE→BUSY on START=1. A and B latch into internal registers, k=0, borrow_in=0.
  - BUSY: each cycle computes chunk k as A_k − B_k − borrow into an internal accumulator, then stores the borrow-out.
  - BUSY→FINISH after chunk NCHUNK−1. On that edge the output registers DIFF, BORROW (final borrow-out) and OVERFLOW load.
  - FINISH→IDLE unconditionally.
- START while READY=0 is ignored, not queued. A and B changes during BUSY have no effect.
- DIFF, BORROW and OVERFLOW hold their last result until the next FINISH entry. They never show partial values.
- Arithmetic is modular with no saturation. Examples: 0 − 1 gives DIFF=all-ones, BORROW=1. A=B gives DIFF=0, BORROW=0.
- Reset:
  - RST=1 at any edge forces IDLE and clears k, the internal registers, DIFF, BORROW, OVERFLOW and DONE. READY is 1 after reset.
  - Reset mid-BUSY abandons the operation; no DONE is produced.
  - RST wins over a simultaneous START.

## Timing
- All outputs are registered.
- Accept edge at cycle t (START=1, READY=1):
  - READY=0 from t+1.
  - BUSY occupies cycles t+1..t+NCHUNK.
  - DONE=1 in cycle t+NCHUNK+1, with results valid in the same cycle.
  - READY=1 again in cycle t+NCHUNK+2.
- Default latency START→DONE is 5 cycles. Throughput is one operation per NCHUNK+2 = 6 cycles.
- Back-to-back use: START held high is accepted again at the first READY=1 edge.
- The critical path is one CHUNK-bit subtract plus the borrow mux, not a 64-bit ripple.

## Structure
- Shared package `arith_pkg`:
  - state enum {IDLE, BUSY, FINISH}
  - default constants WIDTH=64, CHUNK=16
  - derived NCHUNK and chunk-index width $clog2(NCHUNK)
- Sub-module `chunk_subtractor`: purely combinational CHUNK-bit A − B − bin, outputs diff and bout. It is instantiated once and reused across cycles; the operand chunks are selected by k.
- The top level holds the FSM, the counter, the operand, accumulator and borrow registers, and the output registers.
- Elaboration check: WIDTH % CHUNK == 0.

## Test plan
- Reset, then idle:
  - READY=1, DONE=0, DIFF=0, BORROW=0, OVERFLOW=0.
  - START pulse with A=0x0000_0000_0000_0005, B=0x3 → DONE exactly 5 cycles later; DIFF=0x2, BORROW=0, OVERFLOW=0.
- Borrow across all chunks: A=0, B=1 → DIFF=0xFFFF_FFFF_FFFF_FFFF, BORROW=1, OVERFLOW=0.
  - Chunk-boundary borrow: A=0x0000_0001_0000_0000, B=0x1 → DIFF=0x0000_0000_FFFF_FFFF, BORROW=0.
- Signed overflow:
  - A=0x8000_0000_0000_0000, B=0x1 → DIFF=0x7FFF_FFFF_FFFF_FFFF, OVERFLOW=1, BORROW=0.
  - A=0x7FFF_FFFF_FFFF_FFFF, B=0xFFFF_FFFF_FFFF_FFFF → OVERFLOW=1, BORROW=1.
- Handshake:
  - START held high for 20 cycles → exactly 3 DONE pulses, 6 cycles apart.
  - A/B changed during BUSY → result matches the captured operands.
  - START during FINISH → ignored.
- Reset mid-operation: RST=1 during the 2nd BUSY cycle → IDLE next cycle, no DONE, outputs 0. A new START with A=10, B=10 → DIFF=0, BORROW=0.
- Random regression: 1000 random A/B pairs checked against the reference model A − B.
  - Also check that the adder's SUM[63:0] minus B gives A.
